// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
  // imem_req rises with imem_addr and both hold until the cycle imem_ack=1.
  // imem_ack may arrive in the same cycle as the rise; imem_rdata is valid only when it does.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single outstanding imem requests into a small prefetch buffer.
// FETCH_PREFETCH_EN defined gives a 2-entry buffer; undefined gives a 1-entry buffer.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      En_StallF,
  input  logic                      BranchTakenE,
  input  logic [31:0]               PCTarget_E,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               InstrF,
  output logic [31:0]               PC_F,
  output logic [31:0]               PCP4_F,
  output logic                      ValidF,
  output logic [1:0]                fsm_state
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc, req_addr, target;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic [1:0]  count;
  logic        pop, push, room, req_int, wr_idx;

  assign target = PCTarget_E & 32'hFFFF_FFFC;
  assign ValidF = (count != 2'd0);
  assign pop    = ValidF && !En_StallF;
  // A 1-entry buffer may refill in the same cycle its head is consumed.
  assign room   = (count < DEPTH) || ((DEPTH == 2'd1) && pop);
  assign push   = req_int && imem.imem_ack && (state_q != STALE) && !BranchTakenE;
  assign wr_idx = (count != 2'd0) && !((count == 2'd1) && pop);

  always_comb begin
    state_d = state_q;
    req_int = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!BranchTakenE && room) begin
          req_int = 1'b1;
          if (!imem.imem_ack) state_d = BUSY;
        end
      end
      BUSY: begin
        req_int = 1'b1;
        if (imem.imem_ack)     state_d = IDLE;
        else if (BranchTakenE) state_d = STALE;
      end
      STALE: begin
        req_int = 1'b1;
        if (imem.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req  = req_int && rst;
  assign imem.imem_addr = (state_q == IDLE) ? fpc : req_addr;
  assign fsm_state      = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= 2'd0;
    end else begin
      state_q <= state_d;
      // Latch the issue address so a redirect can move fpc while the request is still held.
      if (state_q == IDLE) req_addr <= fpc;
      if (BranchTakenE) begin
        fpc   <= target;
        count <= 2'd0;
      end else begin
        if (push) fpc <= fpc + 32'd4;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      buf_pc[0]    <= buf_pc[1];
      buf_instr[0] <= buf_instr[1];
    end
    if (push) begin
      buf_pc[wr_idx]    <= imem.imem_addr;
      buf_instr[wr_idx] <= imem.imem_rdata;
    end
  end

  assign InstrF = ValidF ? buf_instr[0] : NOP_INSTR;
  assign PC_F   = ValidF ? buf_pc[0] : 32'h0;
  assign PCP4_F = ValidF ? (buf_pc[0] + 32'd4) : 32'h0;

endmodule
